ram_dp_be: RTL and testbench
============================

# ram_dp_be

Single-clock true dual-port RAM with per-byte write enables, configurable read latency, selectable read-during-write semantics, deterministic same-address write collision resolution, and a collision event output for the PMUs. Successor of the dual-clock byte-enable RAM. It is the storage element behind the AXI slave memory endpoints on the NoC. Each port independently issues one read or write per cycle; reads return with a fixed latency and a valid strobe.

## Interface

- ADDR_WIDTH, 10, word address width; depth = 2**ADDR_WIDTH words
- BATCH_WIDTH, 4, bytes per word; width of byte-enable buses
- BYTE_WIDTH, 8, bits per byte; word width DW = BYTE_WIDTH*BATCH_WIDTH
- READ_LATENCY, 1, 1 or 2 cycles from request to rdata/rvalid; any other value is an elaboration error
- WRITE_FIRST, 0, 0 = read-first (old data returned), 1 = write-first (new data returned)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_a  in  1  port A request valid
- we_a  in  1  port A write (1) / read (0); ignored when req_a=0
- addr_a  in  ADDR_WIDTH  port A word address
- wdata_a  in  DW  port A write data; byte i = wdata_a[i*BYTE_WIDTH +: BYTE_WIDTH]
- be_a  in  BATCH_WIDTH  port A byte enables
- rdata_a  out  DW  port A read data
- rvalid_a  out  1  port A read data valid, one-cycle pulse per read
- req_b, we_b, addr_b, wdata_b, be_b, rdata_b, rvalid_b  same as port A, for port B
- coll  out  1  one-cycle pulse: both ports wrote the same address in the same cycle with overlapping byte enables

## Operation

- Write: req_x=1, we_x=1 → bytes with be_x[i]=1 updated at the clock edge; others unchanged. be_x=0 write is legal, no memory change.
- Read: req_x=1, we_x=0 → full word returned after READ_LATENCY cycles with rvalid_x=1. be_x ignored on reads.
- Write also returns data: every accepted write produces rvalid_x after READ_LATENCY with the word selected by WRITE_FIRST (read-first: pre-write word; write-first: post-write merged word, including the other port's same-cycle bytes).
- Cross-port read-during-write (A reads addr X while B writes X, same cycle): WRITE_FIRST=0 → A gets old word; WRITE_FIRST=1 → A gets merged new word. Symmetric for B.
- Write-write collision on same address: per byte, if both be_a[i] and be_b[i] set, port A wins; bytes enabled by only one port take that port's data. coll asserted next cycle iff (be_a & be_b) != 0.
- No backpressure: both ports accept every cycle; no ready signals.
- Memory contents are not reset and are X after power-up; rst clears only pipeline state.
- READ_LATENCY=2 adds one output register stage after the array read register; stage 2 captures stage 1 unconditionally.

## Timing

- Reset values: rdata_a=rdata_b=0, rvalid_a=rvalid_b=0, coll=0; all read pipeline valid bits cleared.
- Request at edge N → rvalid/rdata valid during cycle after edge N+READ_LATENCY-1 (latency 1: visible after edge N; latency 2: after edge N+1).
- rdata holds its last value when rvalid=0 (no clearing except by rst).
- Back-to-back requests sustain one result per cycle per port.
- Write at edge N then read same address at edge N+1 (either port) always returns the written data, independent of WRITE_FIRST.
- rst asserted mid-operation: all in-flight reads dropped, no rvalid emitted for them; a write presented in the same cycle as rst is still performed (memory is not gated by reset). Requests in the first cycle after rst deasserts are accepted normally.
- coll is registered: pulse one cycle after the colliding edge, cleared by rst.

## Test plan

- Byte-enable write: A writes 0xDEADBEEF be=4'b1111 to 0x010, then 0x11223344 be=4'b0101 → A read of 0x010 returns 0xDE22BE44, rvalid after READ_LATENCY.
- Write-write collision: same cycle A writes 0xAAAAAAAA be=4'b0011, B writes 0xBBBBBBBB be=4'b0110 to 0x020 → read returns 0x00BBAAAA-style merge: bytes[3]=old, [2]=BB, [1]=AA, [0]=AA; coll=1 for one cycle; repeat with disjoint enables → coll stays 0.
- Read-during-write: 0x030 holds 0x01020304; A reads 0x030 while B writes 0x05060708 be=4'hF → WRITE_FIRST=0: rdata_a=0x01020304; WRITE_FIRST=1: rdata_a=0x05060708.
- Latency/throughput: READ_LATENCY=1 and 2, 16 back-to-back reads on both ports to addresses 0..15 preloaded with addr*3 → 16 consecutive rvalid pulses per port, data in order, first pulse exactly READ_LATENCY cycles after first request.
- Reset mid-flight: READ_LATENCY=2, issue read, assert rst next cycle → no rvalid, rdata=0; memory content written before rst still readable after rst deasserts.
- Boundary addresses: write/read 0 and 2**ADDR_WIDTH-1 from both ports with walking-one data → exact data returned, no aliasing.

Source files
------------

// File: rtl/ram_dp_be_if.sv
// ============================================================
// Module   : ram_dp_be_if
// Purpose  : two request/response ports plus collision flag of ram_dp_be
// Revision : 1.0
// ============================================================
`default_nettype none

interface ram_dp_be_if #(
  parameter int ADDR_WIDTH  = 10,
  parameter int BATCH_WIDTH = 4,
  parameter int BYTE_WIDTH  = 8
);
  localparam int DW = BYTE_WIDTH * BATCH_WIDTH;

  logic                   req_a;
  logic                   we_a;
  logic [ADDR_WIDTH-1:0]  addr_a;
  logic [DW-1:0]          wdata_a;
  logic [BATCH_WIDTH-1:0] be_a;
  logic [DW-1:0]          rdata_a;
  logic                   rvalid_a;

  logic                   req_b;
  logic                   we_b;
  logic [ADDR_WIDTH-1:0]  addr_b;
  logic [DW-1:0]          wdata_b;
  logic [BATCH_WIDTH-1:0] be_b;
  logic [DW-1:0]          rdata_b;
  logic                   rvalid_b;

  logic                   coll;

  modport master (
    output req_a, we_a, addr_a, wdata_a, be_a,
    output req_b, we_b, addr_b, wdata_b, be_b,
    input  rdata_a, rvalid_a, rdata_b, rvalid_b, coll
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a, be_a,
    input  req_b, we_b, addr_b, wdata_b, be_b,
    output rdata_a, rvalid_a, rdata_b, rvalid_b, coll
  );
endinterface

`default_nettype wire

// File: rtl/ram_dp_be.sv
// ============================================================
// Module   : ram_dp_be
// Purpose  : single-clock true dual-port RAM with byte enables
// Revision : 1.0
// ============================================================
`default_nettype none

module ram_dp_be #(
  parameter int ADDR_WIDTH   = 10,
  parameter int BATCH_WIDTH  = 4,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 0
) (
  input  logic        clk,
  input  logic        rst,
  ram_dp_be_if.slave  bus
);
  localparam int DW    = BYTE_WIDTH * BATCH_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("ram_dp_be: READ_LATENCY must be 1 or 2");
  end

  logic [DW-1:0] mem_q [DEPTH];

  logic          wr_a;
  logic          wr_b;
  logic [DW-1:0] word_a;
  logic [DW-1:0] word_b;

  logic          rv1_a_d, rv1_a_q, rv1_b_d, rv1_b_q;
  logic [DW-1:0] rd1_a_d, rd1_a_q, rd1_b_d, rd1_b_q;
  logic          coll_d, coll_q;

  assign wr_a = bus.req_a & bus.we_a;
  assign wr_b = bus.req_b & bus.we_b;

  // B is written before A so that A's bytes take precedence on a same-address collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BATCH_WIDTH; i++) begin
      if (wr_b && bus.be_b[i])
        mem_q[bus.addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.wdata_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (wr_a && bus.be_a[i])
        mem_q[bus.addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.wdata_a[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Write-first returns the word as it will look after this edge, both ports' bytes merged.
  always_comb begin
    word_a = mem_q[bus.addr_a];
    word_b = mem_q[bus.addr_b];
    if (WRITE_FIRST != 0) begin
      for (int i = 0; i < BATCH_WIDTH; i++) begin
        if (wr_b && bus.be_b[i] && (bus.addr_b == bus.addr_a))
          word_a[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.wdata_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (wr_a && bus.be_a[i])
          word_a[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.wdata_a[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (wr_b && bus.be_b[i])
          word_b[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.wdata_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (wr_a && bus.be_a[i] && (bus.addr_a == bus.addr_b))
          word_b[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.wdata_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_comb begin
    rv1_a_d = bus.req_a;
    rv1_b_d = bus.req_b;
    rd1_a_d = bus.req_a ? word_a : rd1_a_q;
    rd1_b_d = bus.req_b ? word_b : rd1_b_q;
    coll_d  = wr_a && wr_b && (bus.addr_a == bus.addr_b) && ((bus.be_a & bus.be_b) != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rv1_a_q <= 1'b0;
      rv1_b_q <= 1'b0;
      rd1_a_q <= '0;
      rd1_b_q <= '0;
      coll_q  <= 1'b0;
    end else begin
      rv1_a_q <= rv1_a_d;
      rv1_b_q <= rv1_b_d;
      rd1_a_q <= rd1_a_d;
      rd1_b_q <= rd1_b_d;
      coll_q  <= coll_d;
    end
  end

  assign bus.coll = coll_q;

  if (READ_LATENCY == 2) begin : g_lat2
    logic          rv2_a_d, rv2_a_q, rv2_b_d, rv2_b_q;
    logic [DW-1:0] rd2_a_d, rd2_a_q, rd2_b_d, rd2_b_q;

    always_comb begin
      rv2_a_d = rv1_a_q;
      rv2_b_d = rv1_b_q;
      rd2_a_d = rd1_a_q;
      rd2_b_d = rd1_b_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rv2_a_q <= 1'b0;
        rv2_b_q <= 1'b0;
        rd2_a_q <= '0;
        rd2_b_q <= '0;
      end else begin
        rv2_a_q <= rv2_a_d;
        rv2_b_q <= rv2_b_d;
        rd2_a_q <= rd2_a_d;
        rd2_b_q <= rd2_b_d;
      end
    end

    assign bus.rvalid_a = rv2_a_q;
    assign bus.rvalid_b = rv2_b_q;
    assign bus.rdata_a  = rd2_a_q;
    assign bus.rdata_b  = rd2_b_q;
  end else begin : g_lat1
    assign bus.rvalid_a = rv1_a_q;
    assign bus.rvalid_b = rv1_b_q;
    assign bus.rdata_a  = rd1_a_q;
    assign bus.rdata_b  = rd1_b_q;
  end
endmodule

`default_nettype wire

// File: tb/tb_ram_dp_be.sv
// ============================================================
// Module   : tb_ram_dp_be
// Purpose  : two configurations (lat1/read-first, lat2/write-first) vs a word-level model
// Revision : 1.0
// ============================================================
`default_nettype none

module tb_ram_dp_be;
  localparam int AW    = 10;
  localparam int NB    = 4;
  localparam int BW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_dp_be_if #(.ADDR_WIDTH(AW), .BATCH_WIDTH(NB), .BYTE_WIDTH(BW)) bus1 ();
  ram_dp_be_if #(.ADDR_WIDTH(AW), .BATCH_WIDTH(NB), .BYTE_WIDTH(BW)) bus2 ();

  ram_dp_be #(.ADDR_WIDTH(AW), .BATCH_WIDTH(NB), .BYTE_WIDTH(BW),
              .READ_LATENCY(1), .WRITE_FIRST(0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  ram_dp_be #(.ADDR_WIDTH(AW), .BATCH_WIDTH(NB), .BYTE_WIDTH(BW),
              .READ_LATENCY(2), .WRITE_FIRST(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  // stimulus, index 0 = port A, 1 = port B
  logic          s_req  [2];
  logic          s_we   [2];
  logic [AW-1:0] s_addr [2];
  logic [31:0]   s_wd   [2];
  logic [3:0]    s_be   [2];

  // reference: word memory with per-byte "has been written" flags
  logic [31:0] m  [DEPTH];
  logic [3:0]  kn [DEPTH];

  typedef struct { int due; logic [31:0] d; bit k; } exp_t;
  exp_t        q [2][2][$];
  logic        e_valid [2][2];
  logic [31:0] e_data  [2][2];
  bit          e_known [2][2];
  logic        e_coll  [2];
  int          cyc = 0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input logic [AW-1:0] ad,
                          input logic [31:0] wd, input logic [3:0] be);
    s_req[p] = r; s_we[p] = w; s_addr[p] = ad; s_wd[p] = wd; s_be[p] = be;
  endtask

  task automatic idle();
    set_port(0, 0, 0, '0, '0, '0);
    set_port(1, 0, 0, '0, '0, '0);
  endtask

  task automatic tick();
    logic [31:0] oldw [2];
    logic [31:0] neww [2];
    bit          oldk [2];
    bit          newk [2];
    bit          wr   [2];
    bit          cl;
    logic        a_rv [2][2];
    logic [31:0] a_rd [2][2];
    logic        a_cl [2];
    exp_t        e;

    bus1.req_a = s_req[0]; bus1.we_a = s_we[0]; bus1.addr_a = s_addr[0]; bus1.wdata_a = s_wd[0]; bus1.be_a = s_be[0];
    bus1.req_b = s_req[1]; bus1.we_b = s_we[1]; bus1.addr_b = s_addr[1]; bus1.wdata_b = s_wd[1]; bus1.be_b = s_be[1];
    bus2.req_a = s_req[0]; bus2.we_a = s_we[0]; bus2.addr_a = s_addr[0]; bus2.wdata_a = s_wd[0]; bus2.be_a = s_be[0];
    bus2.req_b = s_req[1]; bus2.we_b = s_we[1]; bus2.addr_b = s_addr[1]; bus2.wdata_b = s_wd[1]; bus2.be_b = s_be[1];

    for (int p = 0; p < 2; p++) begin
      wr[p]   = s_req[p] && s_we[p];
      oldw[p] = m[s_addr[p]];
      oldk[p] = (kn[s_addr[p]] == 4'hF);
    end
    cl = wr[0] && wr[1] && (s_addr[0] == s_addr[1]) && ((s_be[0] & s_be[1]) != 4'h0);
    // apply B then A: A overwrites any shared byte
    for (int p = 1; p >= 0; p--)
      for (int i = 0; i < NB; i++)
        if (wr[p] && s_be[p][i]) begin
          m[s_addr[p]][8*i +: 8] = s_wd[p][8*i +: 8];
          kn[s_addr[p]][i] = 1'b1;
        end
    for (int p = 0; p < 2; p++) begin
      neww[p] = m[s_addr[p]];
      newk[p] = (kn[s_addr[p]] == 4'hF);
    end

    // d=0: latency 1, read-first; d=1: latency 2, write-first
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (rst) begin
          q[d][p].delete();
          e_valid[d][p] = 1'b0;
          e_data[d][p]  = '0;
          e_known[d][p] = 1'b1;
        end else begin
          if (s_req[p]) begin
            e.due = cyc + d;
            e.d   = (d == 1) ? neww[p] : oldw[p];
            e.k   = (d == 1) ? newk[p] : oldk[p];
            q[d][p].push_back(e);
          end
          e_valid[d][p] = 1'b0;
          if (q[d][p].size() > 0 && q[d][p][0].due == cyc) begin
            e = q[d][p].pop_front();
            e_valid[d][p] = 1'b1;
            e_data[d][p]  = e.d;
            e_known[d][p] = e.k;
          end
        end
      end
      e_coll[d] = rst ? 1'b0 : cl;
    end
    cyc++;

    @(posedge clk);
    #1;
    a_rv[0][0] = bus1.rvalid_a; a_rv[0][1] = bus1.rvalid_b; a_rd[0][0] = bus1.rdata_a; a_rd[0][1] = bus1.rdata_b;
    a_rv[1][0] = bus2.rvalid_a; a_rv[1][1] = bus2.rvalid_b; a_rd[1][0] = bus2.rdata_a; a_rd[1][1] = bus2.rdata_b;
    a_cl[0] = bus1.coll; a_cl[1] = bus2.coll;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("dut%0d_rvalid_%s", d + 1, p ? "b" : "a"), {31'd0, a_rv[d][p]}, {31'd0, e_valid[d][p]});
        if (e_known[d][p])
          chk($sformatf("dut%0d_rdata_%s", d + 1, p ? "b" : "a"), a_rd[d][p], e_data[d][p]);
      end
      chk($sformatf("dut%0d_coll", d + 1), {31'd0, a_cl[d]}, {31'd0, e_coll[d]});
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) kn[i] = 4'h0;
    idle();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_rdata_a1",  bus1.rdata_a, 32'h0);
    chk("rst_rdata_b2",  bus2.rdata_b, 32'h0);
    chk("rst_rvalid_a2", {31'd0, bus2.rvalid_a}, 32'h0);
    chk("rst_coll1",     {31'd0, bus1.coll}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH / 2; i++) begin
      set_port(0, 1, 1, AW'(i), $urandom, 4'hF);
      set_port(1, 1, 1, AW'(i + DEPTH / 2), $urandom, 4'hF);
      tick();
    end
    idle();

    // byte-enable merge
    set_port(0, 1, 1, 10'h010, 32'hDEADBEEF, 4'hF); tick();
    set_port(0, 1, 1, 10'h010, 32'h11223344, 4'h5); tick();
    set_port(0, 1, 0, 10'h010, 32'h0, 4'h0); tick();
    chk("be_merge_d1", bus1.rdata_a, 32'hDE22BE44);
    chk("be_rvalid_d1", {31'd0, bus1.rvalid_a}, 32'h1);
    idle(); tick();
    chk("be_merge_d2", bus2.rdata_a, 32'hDE22BE44);

    // overlapping write-write collision, then disjoint
    set_port(0, 1, 1, 10'h020, 32'h12345678, 4'hF); tick();
    set_port(0, 1, 1, 10'h020, 32'hAAAAAAAA, 4'h3);
    set_port(1, 1, 1, 10'h020, 32'hBBBBBBBB, 4'h6); tick();
    chk("coll_pulse_d1", {31'd0, bus1.coll}, 32'h1);
    chk("coll_pulse_d2", {31'd0, bus2.coll}, 32'h1);
    idle(); tick();
    chk("coll_clear_d1", {31'd0, bus1.coll}, 32'h0);
    set_port(0, 1, 0, 10'h020, 32'h0, 4'h0); tick();
    chk("coll_merge_d1", bus1.rdata_a, 32'h12BBAAAA);
    set_port(0, 1, 1, 10'h020, 32'hAAAAAAAA, 4'h3);
    set_port(1, 1, 1, 10'h020, 32'hBBBBBBBB, 4'hC); tick();
    chk("coll_disjoint_d1", {31'd0, bus1.coll}, 32'h0);
    idle();
    set_port(1, 1, 0, 10'h020, 32'h0, 4'h0); tick();
    chk("disjoint_merge_d1", bus1.rdata_b, 32'hBBBBAAAA);

    // cross-port read-during-write
    idle();
    set_port(0, 1, 1, 10'h030, 32'h01020304, 4'hF); tick();
    set_port(0, 1, 0, 10'h030, 32'h0, 4'h0);
    set_port(1, 1, 1, 10'h030, 32'h05060708, 4'hF); tick();
    chk("rdw_old_d1", bus1.rdata_a, 32'h01020304);
    idle(); tick();
    chk("rdw_new_d2", bus2.rdata_a, 32'h05060708);

    // back-to-back reads of addr*3
    for (int i = 0; i < 8; i++) begin
      set_port(0, 1, 1, AW'(i), 32'(i * 3), 4'hF);
      set_port(1, 1, 1, AW'(i + 8), 32'((i + 8) * 3), 4'hF);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      set_port(0, 1, 0, AW'(i), 32'h0, 4'h0);
      set_port(1, 1, 0, AW'(i), 32'h0, 4'h0);
      tick();
      chk("b2b_d1_a", bus1.rdata_a, 32'(i * 3));
      chk("b2b_d1_b", bus1.rdata_b, 32'(i * 3));
      if (i > 0) chk("b2b_d2_a", bus2.rdata_a, 32'((i - 1) * 3));
    end
    idle(); tick();
    chk("b2b_d2_last", bus2.rdata_a, 32'd45);
    chk("b2b_d1_hold", bus1.rdata_a, 32'd45);

    // reset with a read in flight; write during reset still lands
    set_port(0, 1, 0, 10'h030, 32'h0, 4'h0); tick();
    idle();
    set_port(1, 1, 1, 10'h040, 32'hCAFEF00D, 4'hF);
    rst = 1'b1; tick();
    chk("rst_flight_rvalid_d2", {31'd0, bus2.rvalid_a}, 32'h0);
    chk("rst_flight_rdata_d2", bus2.rdata_a, 32'h0);
    rst = 1'b0; idle();
    set_port(0, 1, 0, 10'h030, 32'h0, 4'h0);
    set_port(1, 1, 0, 10'h040, 32'h0, 4'h0); tick();
    chk("post_rst_d1_a", bus1.rdata_a, 32'h05060708);
    chk("post_rst_d1_b", bus1.rdata_b, 32'hCAFEF00D);
    idle(); tick();

    // boundary addresses with walking ones
    for (int k = 0; k < 32; k++) begin
      set_port(0, 1, 1, 10'h000, 32'h1 << k, 4'hF);
      set_port(1, 1, 1, 10'h3FF, 32'h1 << (31 - k), 4'hF); tick();
      set_port(0, 1, 0, 10'h3FF, 32'h0, 4'h0);
      set_port(1, 1, 0, 10'h000, 32'h0, 4'h0); tick();
      chk("edge_top_d1", bus1.rdata_a, 32'h1 << (31 - k));
      chk("edge_zero_d1", bus1.rdata_b, 32'h1 << k);
    end

    // random traffic over a small window to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int p = 0; p < 2; p++)
        set_port(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                 ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)),
                 $urandom, 4'($urandom));
      tick();
    end
    rst = 1'b0; idle();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
